demux_1to4_dispatcher: RTL and testbench
========================================

# demux_1to4_dispatcher

Registered stream dispatcher that sequences the 1-to-4 64-bit demultiplexer datapath. It accepts beats on a single valid/ready input and steers each beat to one of four output channels, either round-robin or by an explicit per-beat destination. It holds each beat in a one-entry output stage until the selected channel accepts it. It sits between a single producer and four consumers, replacing a free-running `sel` with flow-controlled scheduling.

## Interface
- `width`, 64, data width of input and each output channel
- `clk` input 1 — rising-edge clock, single clock domain
- `rst_n` input 1 — asynchronous active-low reset
- `i` input `width` — input beat data
- `i_valid` input 1 — input beat present
- `i_ready` output 1 — dispatcher can accept a beat this cycle
- `mode` input 1 — 0 = round-robin, 1 = fixed destination from `dest`
- `dest` input 2 — destination channel when `mode`=1, sampled with the beat
- `o0`..`o3` output `width` each — channel data; zero unless that channel holds the beat
- `o_valid` output 4 — one-hot valid, bit k for channel k; all zero when empty
- `o_ready` input 4 — per-channel consumer ready
- `sel` output 2 — channel of the held beat; last channel when empty
- `rr_ptr` output 2 — next round-robin destination
- `beat_cnt` output 16 — count of beats delivered to consumers

## Operation
- Single-entry holding register with fields `full`, `data`, and `ch[1:0]`.
- Input acceptance: `acc = i_valid & i_ready`.
- `i_ready = !full | o_ready[ch]` (combinational). It accepts into an empty stage, or into a stage draining in the same cycle.
- Output delivery: `dlv = full & o_ready[ch]`.
- Destination select at acceptance: `mode`=0 gives `rr_ptr`; `mode`=1 gives `dest`.
- `rr_ptr` advances by 1 (wrapping 3→0) only on `acc` with `mode`=0. In fixed mode it is unchanged.
- Register update per clock:
  - `acc` only: `full`←1, load `data` and `ch`.
  - `dlv` only: `full`←0. `data` and `ch` are retained.
  - `acc` and `dlv` together: load the new beat and keep `full`=1. No bubble.
- Output decode is a demux of the holding register:
  - `o_valid[k] = full & (ch==k)`.
  - `ok = (full & ch==k) ? data : 0`.
  - Exactly one `o_valid` bit is set when full; none when empty.
- `sel` = `ch`.
- `beat_cnt` increments by 1 on each `dlv` and wraps 0xFFFF→0x0000.
- `o_ready` bits of non-selected channels are ignored.
- `i_valid`=0 with `i_ready`=1 is idle; nothing changes except a drain.
- `mode` and `dest` are don't-care when `acc`=0.
- A beat may be stalled indefinitely. While stalled, `data`, `ch`, and `o_valid` stay stable; `i` and `dest` may change freely.

## Timing
- Reset (async assert, sync release at the next `clk` edge) values:
  - `full`=0
  - `o_valid`=4'b0000
  - `o0`..`o3`=0
  - `sel`=0
  - `rr_ptr`=0
  - `beat_cnt`=0
  - `i_ready`=1 after release
- Beats presented while `rst_n`=0 are not accepted.
- Reset mid-transfer: a held beat is discarded and not counted. `rr_ptr` returns to 0.
- Latency: a beat accepted at edge N is visible on `ok`/`o_valid[k]` after edge N, i.e. in cycle N+1.
- Throughput: 1 beat/cycle when the selected channel holds `o_ready` high.
- `beat_cnt` reflects a delivery at edge N after edge N.
- Outputs and `sel` are registered-derived. Only `i_ready` has a combinational path from `o_ready`.
- Back-pressure: with `full`=1 and `o_ready[ch]`=0, `i_ready`=0 in the same cycle.

## Test plan
- **Reset defaults.** Assert `rst_n`=0 for 3 cycles with `i_valid`=1 and `i`=64'hFFFF. Required response: `o_valid`=0, all `ok`=0, `rr_ptr`=0, `beat_cnt`=0; after release, `i_ready`=1.
- **Round-robin streaming.** `mode`=0, `o_ready`=4'hF, send beats 64'h10, 11, 12, 13, 14 back-to-back. Required response: `o_valid` sequence 0001, 0010, 0100, 1000, 0001; `o0`=64'h10 then 64'h14; no bubbles; `beat_cnt`=5; `rr_ptr`=1.
- **Fixed mode.** `mode`=1, `dest`=2, `i`=64'hA5A5_0000_0000_5A5A. Required response: next cycle `o_valid`=0100, `o2` equals input, `o0`/`o1`/`o3`=0; `rr_ptr` unchanged.
- **Stall and release.** Hold beat 64'h55 on channel 1 with `o_ready`=4'b1101 for 4 cycles. Required response: `i_ready`=0 and `o1` stable throughout. Then set `o_ready[1]`=1 with a new beat 64'h66 valid. Required response: simultaneous drain and accept; next cycle `o_valid`=0010 with 64'h66, `beat_cnt`+1.
- **Counter wrap.** Force 65,536 deliveries. Required response: `beat_cnt` reads 0xFFFF then 0x0000.
- **Reset mid-operation.** Assert `rst_n` while `full`=1 on channel 3 and `rr_ptr`=2. Required response: immediately `o_valid`=0, `o3`=0, `rr_ptr`=0; the held beat is never delivered.

Source files
------------

// File: rtl/demux_1to4_dispatcher.sv
// demux_1to4_dispatcher: one-entry registered stream dispatcher
// steering each input beat to one of four valid/ready channels.
module demux_1to4_dispatcher #(
  parameter int width = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [width-1:0] i,
  input  logic             i_valid,
  output logic             i_ready,
  input  logic             mode,
  input  logic [1:0]       dest,
  output logic [width-1:0] o0,
  output logic [width-1:0] o1,
  output logic [width-1:0] o2,
  output logic [width-1:0] o3,
  output logic [3:0]       o_valid,
  input  logic [3:0]       o_ready,
  output logic [1:0]       sel,
  output logic [1:0]       rr_ptr,
  output logic [15:0]      beat_cnt
);

  logic             full_q, full_d;
  logic [width-1:0] data_q, data_d;
  logic [1:0]       ch_q, ch_d;
  logic [1:0]       rr_q, rr_d;
  logic [15:0]      cnt_q, cnt_d;

  logic             acc;
  logic             dlv;
  logic             ch_rdy;
  logic [1:0]       dsel;

  // Handshake terms; i_ready sees o_ready so a draining stage refills
  always_comb begin
    ch_rdy  = o_ready[ch_q];
    i_ready = !full_q || ch_rdy;
    acc     = i_valid && i_ready;
    dlv     = full_q && ch_rdy;
    dsel    = mode ? dest : rr_q;
  end

  // Next-state for the holding stage, rr pointer and delivery counter
  always_comb begin
    full_d = full_q;
    data_d = data_q;
    ch_d   = ch_q;
    rr_d   = rr_q;
    cnt_d  = cnt_q;
    if (acc) begin
      full_d = 1'b1;
      data_d = i;
      ch_d   = dsel;
    end else if (dlv) begin
      full_d = 1'b0;
    end
    if (acc && !mode) begin
      rr_d = rr_q + 2'd1;
    end
    if (dlv) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_q <= 1'b0;
      data_q <= '0;
      ch_q   <= 2'd0;
      rr_q   <= 2'd0;
      cnt_q  <= 16'd0;
    end else begin
      full_q <= full_d;
      data_q <= data_d;
      ch_q   <= ch_d;
      rr_q   <= rr_d;
      cnt_q  <= cnt_d;
    end
  end

  // Demux of the holding register onto the four channels
  always_comb begin
    o_valid = 4'b0000;
    o0      = '0;
    o1      = '0;
    o2      = '0;
    o3      = '0;
    if (full_q) begin
      unique case (ch_q)
        2'd0: begin
          o_valid = 4'b0001;
          o0      = data_q;
        end
        2'd1: begin
          o_valid = 4'b0010;
          o1      = data_q;
        end
        2'd2: begin
          o_valid = 4'b0100;
          o2      = data_q;
        end
        2'd3: begin
          o_valid = 4'b1000;
          o3      = data_q;
        end
        default: o_valid = 4'b0000;
      endcase
    end
  end

  // Status outputs straight from registers
  always_comb begin
    sel      = ch_q;
    rr_ptr   = rr_q;
    beat_cnt = cnt_q;
  end

endmodule

// File: tb/tb_demux_1to4_dispatcher.sv
// tb_demux_1to4_dispatcher: directed self-checking bench
// for the 1-to-4 registered stream dispatcher.
module tb_demux_1to4_dispatcher;

  logic        clk;
  logic        rst_n;
  logic [63:0] i;
  logic        i_valid;
  logic        i_ready;
  logic        mode;
  logic [1:0]  dest;
  logic [63:0] o0, o1, o2, o3;
  logic [3:0]  o_valid;
  logic [3:0]  o_ready;
  logic [1:0]  sel;
  logic [1:0]  rr_ptr;
  logic [15:0] beat_cnt;

  int tests;
  int failed;

  demux_1to4_dispatcher #(.width(64)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .i        (i),
    .i_valid  (i_valid),
    .i_ready  (i_ready),
    .mode     (mode),
    .dest     (dest),
    .o0       (o0),
    .o1       (o1),
    .o2       (o2),
    .o3       (o3),
    .o_valid  (o_valid),
    .o_ready  (o_ready),
    .sel      (sel),
    .rr_ptr   (rr_ptr),
    .beat_cnt (beat_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_outs(input string tag, input logic [3:0] ev,
                          input logic [63:0] e0, input logic [63:0] e1,
                          input logic [63:0] e2, input logic [63:0] e3);
    chk({tag, ".o_valid"}, {60'd0, o_valid}, {60'd0, ev});
    chk({tag, ".o0"}, o0, e0);
    chk({tag, ".o1"}, o1, e1);
    chk({tag, ".o2"}, o2, e2);
    chk({tag, ".o3"}, o3, e3);
  endtask

  initial begin
    logic [63:0] rr_data [5];
    logic [3:0]  rr_vld  [5];
    tests   = 0;
    failed  = 0;
    rr_data = '{64'h10, 64'h11, 64'h12, 64'h13, 64'h14};
    rr_vld  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

    // reset defaults with a beat presented during reset
    rst_n   = 1'b0;
    i       = 64'hFFFF;
    i_valid = 1'b1;
    mode    = 1'b0;
    dest    = 2'd0;
    o_ready = 4'hF;
    repeat (3) tick();
    chk_outs("rst", 4'b0000, 64'd0, 64'd0, 64'd0, 64'd0);
    chk("rst.rr_ptr", {62'd0, rr_ptr}, 64'd0);
    chk("rst.beat_cnt", {48'd0, beat_cnt}, 64'd0);
    chk("rst.sel", {62'd0, sel}, 64'd0);
    i_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("rst.i_ready", {63'd0, i_ready}, 64'd1);
    chk("rst.idle_valid", {60'd0, o_valid}, 64'd0);

    // round-robin streaming, back to back
    for (int k = 0; k < 5; k++) begin
      i       = rr_data[k];
      i_valid = 1'b1;
      #1;
      chk($sformatf("rr%0d.i_ready", k), {63'd0, i_ready}, 64'd1);
      tick();
      chk($sformatf("rr%0d.o_valid", k), {60'd0, o_valid},
          {60'd0, rr_vld[k]});
      chk($sformatf("rr%0d.cnt", k), {48'd0, beat_cnt}, 64'(k));
    end
    chk("rr.o0_last", o0, 64'h14);
    i_valid = 1'b0;
    tick();
    chk("rr.beat_cnt", {48'd0, beat_cnt}, 64'd5);
    chk("rr.rr_ptr", {62'd0, rr_ptr}, 64'd1);
    chk("rr.drained", {60'd0, o_valid}, 64'd0);

    // fixed destination
    mode    = 1'b1;
    dest    = 2'd2;
    i       = 64'hA5A5_0000_0000_5A5A;
    i_valid = 1'b1;
    tick();
    i_valid = 1'b0;
    chk_outs("fix", 4'b0100, 64'd0, 64'd0, 64'hA5A5_0000_0000_5A5A, 64'd0);
    chk("fix.rr_ptr", {62'd0, rr_ptr}, 64'd1);
    chk("fix.sel", {62'd0, sel}, 64'd2);
    tick();
    chk("fix.beat_cnt", {48'd0, beat_cnt}, 64'd6);

    // stall on channel 1 and release with simultaneous accept
    dest    = 2'd1;
    i       = 64'h55;
    o_ready = 4'b1101;
    i_valid = 1'b1;
    tick();
    chk_outs("stl.load", 4'b0010, 64'd0, 64'h55, 64'd0, 64'd0);
    for (int k = 0; k < 4; k++) begin
      i    = 64'h77 + 64'(k);
      dest = 2'(k);
      #1;
      chk($sformatf("stl%0d.i_ready", k), {63'd0, i_ready}, 64'd0);
      tick();
      chk($sformatf("stl%0d.o1", k), o1, 64'h55);
      chk($sformatf("stl%0d.o_valid", k), {60'd0, o_valid}, 64'b0010);
    end
    chk("stl.cnt_held", {48'd0, beat_cnt}, 64'd6);
    o_ready = 4'hF;
    dest    = 2'd1;
    i       = 64'h66;
    #1;
    chk("stl.rel_i_ready", {63'd0, i_ready}, 64'd1);
    tick();
    i_valid = 1'b0;
    chk_outs("stl.rel", 4'b0010, 64'd0, 64'h66, 64'd0, 64'd0);
    chk("stl.rel_cnt", {48'd0, beat_cnt}, 64'd7);
    tick();
    chk("stl.drain_cnt", {48'd0, beat_cnt}, 64'd8);

    // reset while channel 3 is held and rr_ptr is 2
    mode    = 1'b0;
    i       = 64'hBEEF;
    i_valid = 1'b1;
    tick();
    chk("mid.rr_ptr2", {62'd0, rr_ptr}, 64'd2);
    chk("mid.ch1", {60'd0, o_valid}, 64'b0010);
    mode    = 1'b1;
    dest    = 2'd3;
    i       = 64'hDEAD;
    o_ready = 4'b0010;
    tick();
    i_valid = 1'b0;
    o_ready = 4'b0000;
    chk_outs("mid.held", 4'b1000, 64'd0, 64'd0, 64'd0, 64'hDEAD);
    chk("mid.rr_hold", {62'd0, rr_ptr}, 64'd2);
    chk("mid.cnt", {48'd0, beat_cnt}, 64'd9);
    #2;
    rst_n = 1'b0;
    #1;
    chk_outs("mid.rst", 4'b0000, 64'd0, 64'd0, 64'd0, 64'd0);
    chk("mid.rst_rr", {62'd0, rr_ptr}, 64'd0);
    o_ready = 4'hF;
    tick();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) tick();
    chk("mid.no_dlv", {48'd0, beat_cnt}, 64'd0);
    chk("mid.empty", {60'd0, o_valid}, 64'd0);

    // counter wrap: 65536 deliveries from zero
    mode    = 1'b0;
    i       = 64'h1;
    i_valid = 1'b1;
    repeat (65536) tick();
    chk("wrap.ffff", {48'd0, beat_cnt}, 64'hFFFF);
    i_valid = 1'b0;
    tick();
    chk("wrap.zero", {48'd0, beat_cnt}, 64'h0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
